// File: rtl/sdio_wb_pkg.sv
// Shared types and field widths for the SDIO Wishbone arbiter slice.
package sdio_wb_pkg;
  localparam int CTI_W = 3;
  localparam int BTE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;
endpackage

// File: rtl/sdio_wb_watchdog.sv
// Stall watchdog: counts strobe cycles without termination and pulses fire on the last one.
module sdio_wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic term,
  output logic fire
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // A slave termination in the fire cycle wins, so term masks fire.
  assign fire = stb && !term && (count == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!stb || term || fire) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/sdio_wb_arbiter.sv
// Two-master Wishbone B4 classic arbiter in front of the SDIO slave port.
// Round-robin grant held for a full cyc tenure; the watchdog ends stalled cycles with err.
module sdio_wb_arbiter
  import sdio_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_cyc_m2s,
  input  logic                  m0_stb_m2s,
  input  logic                  m0_we_m2s,
  input  logic [ADDR_WIDTH-1:0] m0_adr_m2s,
  input  logic [DATA_WIDTH-1:0] m0_dat_m2s,
  input  logic [CTI_W-1:0]      m0_cti_m2s,
  input  logic [BTE_W-1:0]      m0_bte_m2s,
  output logic                  m0_ack_s2m,
  output logic                  m0_err_s2m,
  output logic                  m0_rty_s2m,
  output logic [DATA_WIDTH-1:0] m0_dat_s2m,
  input  logic                  m1_cyc_m2s,
  input  logic                  m1_stb_m2s,
  input  logic                  m1_we_m2s,
  input  logic [ADDR_WIDTH-1:0] m1_adr_m2s,
  input  logic [DATA_WIDTH-1:0] m1_dat_m2s,
  input  logic [CTI_W-1:0]      m1_cti_m2s,
  input  logic [BTE_W-1:0]      m1_bte_m2s,
  output logic                  m1_ack_s2m,
  output logic                  m1_err_s2m,
  output logic                  m1_rty_s2m,
  output logic [DATA_WIDTH-1:0] m1_dat_s2m,
  output logic                  s_cyc_m2s,
  output logic                  s_stb_m2s,
  output logic                  s_we_m2s,
  output logic [ADDR_WIDTH-1:0] s_adr_m2s,
  output logic [DATA_WIDTH-1:0] s_dat_m2s,
  output logic [CTI_W-1:0]      s_cti_m2s,
  output logic [BTE_W-1:0]      s_bte_m2s,
  input  logic                  s_ack_s2m,
  input  logic                  s_err_s2m,
  input  logic                  s_rty_s2m,
  input  logic [DATA_WIDTH-1:0] s_dat_s2m,
  output logic [1:0]            gnt,
  output logic                  timeout_evt
);
  arb_state_t state, state_next;
  logic       last;
  logic       stb_raw;
  logic       s_term;
  logic       wd_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      if (state_next == GNT0) last <= 1'b0;
      else if (state_next == GNT1) last <= 1'b1;
    end
  end

  // Grant is locked while the owner keeps cyc high; on release the other
  // requester takes over directly, with no idle cycle in between.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (m0_cyc_m2s && m1_cyc_m2s) state_next = last ? GNT0 : GNT1;
        else if (m0_cyc_m2s)          state_next = GNT0;
        else if (m1_cyc_m2s)          state_next = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_m2s) state_next = m1_cyc_m2s ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!m1_cyc_m2s) state_next = m0_cyc_m2s ? GNT0 : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Wishbone handshake: a beat is offered while cyc & stb are high and
  // completes in the cycle the slave returns exactly one of ack/err/rty.
  assign stb_raw = (state == GNT0) ? m0_stb_m2s :
                   (state == GNT1) ? m1_stb_m2s : 1'b0;
  assign s_term  = s_ack_s2m | s_err_s2m | s_rty_s2m;

  sdio_wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk  (clk),
    .rst  (rst),
    .stb  (stb_raw),
    .term (s_term),
    .fire (wd_fire)
  );

  always_comb begin
    s_cyc_m2s  = 1'b0;
    s_we_m2s   = 1'b0;
    s_adr_m2s  = '0;
    s_dat_m2s  = '0;
    s_cti_m2s  = '0;
    s_bte_m2s  = '0;
    m0_ack_s2m = 1'b0;
    m0_err_s2m = 1'b0;
    m0_rty_s2m = 1'b0;
    m1_ack_s2m = 1'b0;
    m1_err_s2m = 1'b0;
    m1_rty_s2m = 1'b0;
    gnt        = 2'b00;
    unique case (state)
      GNT0: begin
        s_cyc_m2s  = m0_cyc_m2s;
        s_we_m2s   = m0_we_m2s;
        s_adr_m2s  = m0_adr_m2s;
        s_dat_m2s  = m0_dat_m2s;
        s_cti_m2s  = m0_cti_m2s;
        s_bte_m2s  = m0_bte_m2s;
        m0_ack_s2m = s_ack_s2m;
        m0_err_s2m = s_err_s2m | wd_fire;
        m0_rty_s2m = s_rty_s2m;
        gnt        = 2'b01;
      end
      GNT1: begin
        s_cyc_m2s  = m1_cyc_m2s;
        s_we_m2s   = m1_we_m2s;
        s_adr_m2s  = m1_adr_m2s;
        s_dat_m2s  = m1_dat_m2s;
        s_cti_m2s  = m1_cti_m2s;
        s_bte_m2s  = m1_bte_m2s;
        m1_ack_s2m = s_ack_s2m;
        m1_err_s2m = s_err_s2m | wd_fire;
        m1_rty_s2m = s_rty_s2m;
        gnt        = 2'b10;
      end
      default: ;
    endcase
  end

  assign s_stb_m2s   = stb_raw & ~wd_fire;
  assign timeout_evt = wd_fire;
  assign m0_dat_s2m  = s_dat_s2m;
  assign m1_dat_s2m  = s_dat_s2m;
endmodule

// File: tb/tb_sdio_wb_arbiter.sv
// Bench for sdio_wb_arbiter: directed vector table, watchdog/reset sequences, random run vs model.
module tb_sdio_wb_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam logic [AW-1:0] ADR0 = 32'h0000_0010;
  localparam logic [AW-1:0] ADR1 = 32'h0000_0020;
  localparam logic [DW-1:0] DAT0 = 32'hFFFF_FFFF;
  localparam logic [DW-1:0] DAT1 = 32'hA5A5_0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_adr, m1_adr, s_adr;
  logic [DW-1:0] m0_dat, m1_dat, s_dat, m0_rdat, m1_rdat, s_rdat;
  logic [2:0]    m0_cti, m1_cti, s_cti;
  logic [1:0]    m0_bte, m1_bte, s_bte;
  logic          m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic          s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
  logic [1:0]    gnt;
  logic          timeout_evt;

  sdio_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_m2s(m0_cyc), .m0_stb_m2s(m0_stb), .m0_we_m2s(m0_we), .m0_adr_m2s(m0_adr),
    .m0_dat_m2s(m0_dat), .m0_cti_m2s(m0_cti), .m0_bte_m2s(m0_bte),
    .m0_ack_s2m(m0_ack), .m0_err_s2m(m0_err), .m0_rty_s2m(m0_rty), .m0_dat_s2m(m0_rdat),
    .m1_cyc_m2s(m1_cyc), .m1_stb_m2s(m1_stb), .m1_we_m2s(m1_we), .m1_adr_m2s(m1_adr),
    .m1_dat_m2s(m1_dat), .m1_cti_m2s(m1_cti), .m1_bte_m2s(m1_bte),
    .m1_ack_s2m(m1_ack), .m1_err_s2m(m1_err), .m1_rty_s2m(m1_rty), .m1_dat_s2m(m1_rdat),
    .s_cyc_m2s(s_cyc), .s_stb_m2s(s_stb), .s_we_m2s(s_we), .s_adr_m2s(s_adr),
    .s_dat_m2s(s_dat), .s_cti_m2s(s_cti), .s_bte_m2s(s_bte),
    .s_ack_s2m(s_ack), .s_err_s2m(s_err), .s_rty_s2m(s_rty), .s_dat_s2m(s_rdat),
    .gnt(gnt), .timeout_evt(timeout_evt)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0; m0_cti = '0; m0_bte = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0; m1_cti = '0; m1_bte = '0;
    s_ack = 0; s_err = 0; s_rty = 0; s_rdat = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0] cyc;
    logic [1:0] stb;
    logic       ack;
    logic [1:0] e_gnt;
    logic       e_cyc;
    logic       e_stb;
    logic [1:0] e_ack;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic [1:0] cyc, input logic [1:0] stb, input logic ack,
                              input logic [1:0] e_gnt, input logic e_cyc, input logic e_stb,
                              input logic [1:0] e_ack);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.ack = ack;
    v.e_gnt = e_gnt; v.e_cyc = e_cyc; v.e_stb = e_stb; v.e_ack = e_ack;
    return v;
  endfunction

  task automatic run_table();
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [2:0]    e_cti;
    // tie after reset -> m0; m1 follows m0 release; m1 4-beat burst holds the grant
    tbl[0]  = mk(2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00);
    tbl[1]  = mk(2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00);
    tbl[2]  = mk(2'b11, 2'b11, 1, 2'b01, 1, 1, 2'b01);
    tbl[3]  = mk(2'b10, 2'b10, 0, 2'b01, 0, 0, 2'b00);
    tbl[4]  = mk(2'b10, 2'b10, 1, 2'b10, 1, 1, 2'b10);
    tbl[5]  = mk(2'b11, 2'b11, 1, 2'b10, 1, 1, 2'b10);
    tbl[6]  = mk(2'b11, 2'b11, 1, 2'b10, 1, 1, 2'b10);
    tbl[7]  = mk(2'b11, 2'b11, 1, 2'b10, 1, 1, 2'b10);
    tbl[8]  = mk(2'b01, 2'b01, 0, 2'b10, 0, 0, 2'b00);
    tbl[9]  = mk(2'b01, 2'b01, 1, 2'b01, 1, 1, 2'b01);
    tbl[10] = mk(2'b00, 2'b00, 0, 2'b01, 0, 0, 2'b00);
    tbl[11] = mk(2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00);
    tbl[12] = mk(2'b11, 2'b11, 1, 2'b10, 1, 1, 2'b10);
    tbl[13] = mk(2'b00, 2'b00, 0, 2'b10, 0, 0, 2'b00);
    tbl[14] = mk(2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00);
    pulse_reset();
    m0_we = 1; m0_adr = ADR0; m0_dat = DAT0; m0_cti = 3'b000;
    m1_we = 1; m1_adr = ADR1; m1_dat = DAT1; m1_cti = 3'b010;
    for (int i = 0; i < 15; i++) begin
      m0_cyc = tbl[i].cyc[0]; m0_stb = tbl[i].stb[0];
      m1_cyc = tbl[i].cyc[1]; m1_stb = tbl[i].stb[1];
      s_ack  = tbl[i].ack;
      s_rdat = 32'h1234_0000 + i;
      e_adr = (tbl[i].e_gnt == 2'b01) ? ADR0 : (tbl[i].e_gnt == 2'b10) ? ADR1 : '0;
      e_dat = (tbl[i].e_gnt == 2'b01) ? DAT0 : (tbl[i].e_gnt == 2'b10) ? DAT1 : '0;
      e_cti = (tbl[i].e_gnt == 2'b10) ? 3'b010 : 3'b000;
      @(negedge clk);
      check("tbl_gnt", gnt, tbl[i].e_gnt);
      check("tbl_s_cyc_stb", {s_cyc, s_stb}, {tbl[i].e_cyc, tbl[i].e_stb});
      check("tbl_acks", {m1_ack, m0_ack}, tbl[i].e_ack);
      check("tbl_errs_evt", {m1_err, m0_err, timeout_evt}, 3'b000);
      check("tbl_s_adr_dat_cti", {s_adr, s_dat, s_cti}, {e_adr, e_dat, e_cti});
      check("tbl_rdat", {m1_rdat, m0_rdat}, {2{32'h1234_0000 + i}});
      next_cycle();
    end
  endtask

  // ---------------- watchdog sequences (stub slave never acks) ----------------
  task automatic run_watchdog(input bit ack_at_fire);
    bit last_k;
    pulse_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = ADR0; m0_dat = DAT0;
    @(negedge clk);
    check("wd_idle_gnt", gnt, 2'b00);
    next_cycle();
    for (int k = 0; k < TO; k++) begin
      last_k = (k == TO - 1);
      s_ack = ack_at_fire && last_k;
      @(negedge clk);
      check("wd_evt", timeout_evt, !ack_at_fire && last_k);
      check("wd_m0_err", m0_err, !ack_at_fire && last_k);
      check("wd_m0_ack", m0_ack, ack_at_fire && last_k);
      check("wd_s_stb", s_stb, !(!ack_at_fire && last_k));
      check("wd_m1_resp", {m1_ack, m1_err, m1_rty}, 3'b000);
      next_cycle();
    end
    s_ack = 0;
    m0_cyc = 0; m0_stb = 0;
    next_cycle();
  endtask

  // ---------------- async reset during a GNT1 tenure ----------------
  task automatic run_reset_midcycle();
    pulse_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = ADR1; m1_dat = DAT1;
    next_cycle();
    @(negedge clk);
    check("rst_pre_gnt", {gnt, s_cyc}, 3'b101);
    rst = 1'b1;
    #1;
    check("rst_async_gnt_cyc", {gnt, s_cyc, s_stb}, 4'b0000);
    @(posedge clk);
    #1 rst = 1'b0;
    m0_cyc = 1; m0_stb = 1; m0_adr = ADR0; m0_dat = DAT0;
    next_cycle();
    @(negedge clk);
    check("rst_tie_to_m0", gnt, 2'b01);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    next_cycle();
  endtask

  // ---------------- random run vs behavioural model ----------------
  // Model: the owner index (-1 = none), the master that won most recently,
  // and how many consecutive cycles the owner's strobe has gone unanswered.
  int owner, last_win, stall;

  task automatic model_step();
    logic [71:0] bus0, bus1, e_bus;
    logic [2:0]  resp, e_r0, e_r1;
    logic        raw_stb, term, fire;
    int          nxt;
    bit          c0, c1;
    bus0 = {m0_cyc, m0_stb, m0_we, m0_adr, m0_dat, m0_cti, m0_bte};
    bus1 = {m1_cyc, m1_stb, m1_we, m1_adr, m1_dat, m1_cti, m1_bte};
    raw_stb = (owner == 0) ? m0_stb : (owner == 1) ? m1_stb : 1'b0;
    term = s_ack | s_err | s_rty;
    fire = raw_stb && !term && (stall == TO - 1);
    e_bus = (owner == 0) ? bus0 : (owner == 1) ? bus1 : 72'd0;
    if (fire) e_bus[70] = 1'b0;
    resp = {s_ack, s_err | fire, s_rty};
    e_r0 = (owner == 0) ? resp : 3'b000;
    e_r1 = (owner == 1) ? resp : 3'b000;
    @(negedge clk);
    check("rnd_gnt", gnt, (owner < 0) ? 2'b00 : (2'b01 << owner));
    check("rnd_evt", timeout_evt, fire);
    check("rnd_s_bus", {s_cyc, s_stb, s_we, s_adr, s_dat, s_cti, s_bte}, e_bus);
    check("rnd_m0_resp", {m0_ack, m0_err, m0_rty}, e_r0);
    check("rnd_m1_resp", {m1_ack, m1_err, m1_rty}, e_r1);
    check("rnd_rdat", {m0_rdat, m1_rdat}, {s_rdat, s_rdat});
    stall = (raw_stb && !term && !fire) ? stall + 1 : 0;
    c0 = m0_cyc; c1 = m1_cyc;
    if (owner < 0) nxt = (c0 && c1) ? 1 - last_win : c0 ? 0 : c1 ? 1 : -1;
    else if ((owner == 0 && c0) || (owner == 1 && c1)) nxt = owner;
    else nxt = ((owner == 0 && c1) || (owner == 1 && c0)) ? 1 - owner : -1;
    if (nxt >= 0) last_win = nxt;
    owner = nxt;
  endtask

  task automatic rand_master(inout logic cyc, output logic stb, output logic we,
                             output logic [AW-1:0] adr, output logic [DW-1:0] dat,
                             output logic [2:0] cti, output logic [1:0] bte);
    if (cyc) cyc = ($urandom_range(0, 5) != 0);
    else     cyc = ($urandom_range(0, 2) == 0);
    stb = cyc ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
    we  = 1'($urandom_range(0, 1));
    adr = $urandom;
    dat = $urandom;
    cti = 3'($urandom_range(0, 7));
    bte = 2'($urandom_range(0, 3));
  endtask

  task automatic run_random(input int cycles);
    pulse_reset();
    owner = -1; last_win = 1; stall = 0;
    for (int n = 0; n < cycles; n++) begin
      rand_master(m0_cyc, m0_stb, m0_we, m0_adr, m0_dat, m0_cti, m0_bte);
      rand_master(m1_cyc, m1_stb, m1_we, m1_adr, m1_dat, m1_cti, m1_bte);
      s_ack  = ($urandom_range(0, 4) == 0);
      s_err  = ($urandom_range(0, 15) == 0);
      s_rty  = ($urandom_range(0, 15) == 0);
      s_rdat = $urandom;
      model_step();
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    check("reset_gnt_evt", {gnt, timeout_evt}, 3'b000);
    check("reset_s_bus", {s_cyc, s_stb, s_we, s_adr, s_dat, s_cti, s_bte}, 72'd0);
    check("reset_resps", {m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}, 6'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_table();
    run_watchdog(1'b0);
    run_watchdog(1'b1);
    run_reset_midcycle();
    run_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
